// File: rtl/main.sv
// Single-precision (binary32) adder/subtractor with one registered output.
// Subnormal inputs are flushed to zero. Underflowing results become signed zero.
// Rounding is round-to-nearest, ties-to-even.
module main (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic        A_S,
    output logic [31:0] Result
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Unpacked operand fields; B's sign already carries the subtract select.
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [30:0] a_mag, b_mag;

    assign a_sign = A_in[31];
    assign b_sign = B_in[31] ^ A_S;
    assign a_exp  = A_in[30:23];
    assign b_exp  = B_in[30:23];
    assign a_frac = A_in[22:0];
    assign b_frac = B_in[22:0];
    assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
    assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign a_zero = (a_exp == 8'd0);
    assign b_zero = (b_exp == 8'd0);
    // Subnormals count as zero magnitude when deciding which operand is larger.
    assign a_mag  = a_zero ? 31'd0 : A_in[30:0];
    assign b_mag  = b_zero ? 31'd0 : B_in[30:0];

    // Larger/smaller operand after the swap.
    logic        l_sign, s_sign;
    logic [7:0]  l_exp, s_exp;
    logic [23:0] l_man, s_man;

    // Swap so the first operand has the larger magnitude.
    always_comb begin
        if (b_mag > a_mag) begin
            l_sign = b_sign;
            l_exp  = b_exp;
            l_man  = {1'b1, b_frac};
            s_sign = a_sign;
            s_exp  = a_exp;
            s_man  = a_zero ? 24'd0 : {1'b1, a_frac};
        end else begin
            l_sign = a_sign;
            l_exp  = a_exp;
            l_man  = {1'b1, a_frac};
            s_sign = b_sign;
            s_exp  = b_exp;
            s_man  = b_zero ? 24'd0 : {1'b1, b_frac};
        end
    end

    // Alignment: smaller significand shifted right, keeping guard/round/sticky.
    logic [7:0]  exp_diff;
    logic [49:0] s_shifted;
    logic [26:0] s_ext, l_ext;

    assign exp_diff = l_exp - s_exp;
    assign l_ext    = {l_man, 3'b000};

    // Shifts of 26 or more leave only the sticky bit of the smaller operand.
    always_comb begin
        s_shifted = 50'd0;
        s_ext     = 27'd0;
        if (exp_diff >= 8'd26) begin
            s_ext = {26'd0, |s_man};
        end else begin
            s_shifted = {s_man, 26'd0} >> exp_diff;
            s_ext     = {s_shifted[49:24], |s_shifted[23:0]};
        end
    end

    // Significand add or subtract; magnitude ordering keeps the difference non-negative.
    logic        eff_sub;
    logic [27:0] sum;

    assign eff_sub = l_sign ^ s_sign;
    assign sum     = eff_sub ? ({1'b0, l_ext} - {1'b0, s_ext})
                             : ({1'b0, l_ext} + {1'b0, s_ext});

    // Leading-zero count of the 27-bit sum below the carry position.
    logic [4:0] lzc;
    logic       lzc_found;

    // Scan from MSB; the first set bit fixes the normalising shift.
    always_comb begin
        lzc       = 5'd0;
        lzc_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lzc_found) begin
                if (sum[i]) begin
                    lzc_found = 1'b1;
                end else begin
                    lzc = lzc + 5'd1;
                end
            end
        end
    end

    // Normalisation, rounding and exponent tracking.
    logic [26:0]       norm;
    logic signed [9:0] exp_norm, exp_final;
    logic              round_up;
    logic [24:0]       man_rnd;
    logic [22:0]       frac_final;

    // Carry-out shifts right by one; otherwise shift left by the leading-zero count.
    always_comb begin
        if (sum[27]) begin
            norm     = {sum[27:2], sum[1] | sum[0]};
            exp_norm = $signed({2'b00, l_exp}) + 10'sd1;
        end else begin
            norm     = sum[26:0] << lzc;
            exp_norm = $signed({2'b00, l_exp}) - $signed({5'd0, lzc});
        end
    end

    // Ties-to-even rounding; a carry from rounding renormalises.
    always_comb begin
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_rnd  = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (man_rnd[24]) begin
            frac_final = man_rnd[23:1];
            exp_final  = exp_norm + 10'sd1;
        end else begin
            frac_final = man_rnd[22:0];
            exp_final  = exp_norm;
        end
    end

    logic [31:0] result_d, result_q;

    // Special-case selection ahead of the finite arithmetic result.
    always_comb begin
        result_d = 32'd0;
        if (a_nan || b_nan) begin
            result_d = QNAN;
        end else if (a_inf && b_inf) begin
            result_d = (a_sign == b_sign) ? {a_sign, 8'hFF, 23'd0} : QNAN;
        end else if (a_inf) begin
            result_d = {a_sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
            result_d = {b_sign, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            // Only -0 plus -0 keeps the negative sign.
            result_d = {a_sign & b_sign, 31'd0};
        end else if (a_zero) begin
            result_d = {b_sign, B_in[30:0]};
        end else if (b_zero) begin
            result_d = A_in;
        end else if (sum == 28'd0) begin
            // Exact cancellation always yields +0.
            result_d = 32'd0;
        end else if (exp_final >= 10'sd255) begin
            result_d = {l_sign, 8'hFF, 23'd0};
        end else if (exp_final <= 10'sd0) begin
            result_d = {l_sign, 31'd0};
        end else begin
            result_d = {l_sign, exp_final[7:0], frac_final};
        end
    end

    // Output register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'd0;
        end else begin
            result_q <= result_d;
        end
    end

    assign Result = result_q;

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for the binary32 adder: the driver queues the expected
// result of each edge, the monitor compares after the edge.
module tb_main;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A_in = 32'd0;
    logic [31:0] B_in = 32'd0;
    logic        A_S = 1'b0;
    logic [31:0] Result;

    int errors = 0;
    int checks = 0;
    int issued = 0;

    typedef struct {
        logic [31:0] exp;
        int          id;
    } sb_t;

    sb_t sb_q[$];

    main dut (
        .clk    (clk),
        .rst    (rst),
        .A_in   (A_in),
        .B_in   (B_in),
        .A_S    (A_S),
        .Result (Result)
    );

    always #5 clk = ~clk;

    // Drive one edge's worth of inputs and queue what that edge must produce.
    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] e);
        sb_t item;
        @(negedge clk);
        rst  = r;
        A_in = a;
        B_in = b;
        A_S  = s;
        item.exp = e;
        item.id  = issued;
        sb_q.push_back(item);
        issued++;
    endtask

    // Monitor: compare the registered output shortly after each edge.
    always @(posedge clk) begin
        sb_t item;
        #1;
        if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            checks++;
            if (Result !== item.exp) begin
                errors++;
                $display("FAIL txn%0d: Result=%08h required=%08h", item.id, Result, item.exp);
            end else begin
                $display("txn%0d ok: Result=%08h", item.id, Result);
            end
        end
    end

    localparam int N = 26;
    logic        v_rst [N];
    logic [31:0] v_a   [N];
    logic [31:0] v_b   [N];
    logic        v_s   [N];
    logic [31:0] v_e   [N];

    task automatic set_vec(input int i, input logic r, input logic [31:0] a,
                           input logic [31:0] b, input logic s, input logic [31:0] e);
        v_rst[i] = r; v_a[i] = a; v_b[i] = b; v_s[i] = s; v_e[i] = e;
    endtask

    initial begin
        // Reset held two cycles with arbitrary operands.
        set_vec(0,  1'b1, 32'h40966666, 32'h40C66666, 1'b0, 32'h00000000);
        set_vec(1,  1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
        // Sign matrix.
        set_vec(2,  1'b0, 32'h40966666, 32'h40C66666, 1'b0, 32'h412E6666);
        set_vec(3,  1'b0, 32'h40966666, 32'h40C66666, 1'b1, 32'hBFC00000);
        set_vec(4,  1'b0, 32'h40966666, 32'hC0C66666, 1'b0, 32'hBFC00000);
        set_vec(5,  1'b0, 32'h40966666, 32'hC0C66666, 1'b1, 32'h412E6666);
        set_vec(6,  1'b0, 32'hC0966666, 32'h40C66666, 1'b0, 32'h3FC00000);
        set_vec(7,  1'b0, 32'hC0966666, 32'h40C66666, 1'b1, 32'hC12E6666);
        set_vec(8,  1'b0, 32'hC0966666, 32'hC0C66666, 1'b0, 32'hC12E6666);
        set_vec(9,  1'b0, 32'hC0966666, 32'hC0C66666, 1'b1, 32'h3FC00000);
        // Small exponents, mixed signs.
        set_vec(10, 1'b0, 32'h81C00000, 32'h00800000, 1'b0, 32'h81A00000);
        // Cancellation and specials.
        set_vec(11, 1'b0, 32'h40966666, 32'h40966666, 1'b1, 32'h00000000);
        set_vec(12, 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
        set_vec(13, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        set_vec(14, 1'b0, 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000);
        // Reset between operations zeroes that cycle only.
        set_vec(15, 1'b1, 32'h40966666, 32'h40C66666, 1'b0, 32'h00000000);
        // Ties-to-even: 1 + 2^-24 stays 1.0; 1+2^-23 + 2^-24 rounds up to even.
        set_vec(16, 1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
        set_vec(17, 1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
        // Zero operands and signed zeros.
        set_vec(18, 1'b0, 32'h00000000, 32'h40966666, 1'b1, 32'hC0966666);
        set_vec(19, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
        set_vec(20, 1'b0, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
        // NaN input and infinity with finite.
        set_vec(21, 1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
        set_vec(22, 1'b0, 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000);
        set_vec(23, 1'b0, 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000);
        // Simple exact sums: 1+1 = 2, 3 - 1 = 2.
        set_vec(24, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        set_vec(25, 1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);

        for (int i = 0; i < N; i++) begin
            drive(v_rst[i], v_a[i], v_b[i], v_s[i], v_e[i]);
        end

        // Drain with a bounded wait for the monitor to consume the queue.
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", sb_q.size());
        end
        if (checks != N + 1) begin
            errors++;
            $display("FAIL count: checks=%0d required=%0d", checks, N + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
